// File: rtl/iic_pkg.sv
// Shared encodings for the IIC command-port arbiter.
package iic_pkg;

  // IIC_module call encodings
  localparam logic [1:0] CALL_NONE  = 2'b00;
  localparam logic [1:0] CALL_READ  = 2'b01;
  localparam logic [1:0] CALL_WRITE = 2'b10;
  localparam logic [1:0] CALL_BAD   = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2,
    HOLD  = 2'd3
  } state_t;

endpackage

// File: rtl/iic_rr_pick.sv
// Combinational round-robin picker: first requester after `last`, with wrap.
module iic_rr_pick #(
  parameter int N_REQ = 3,
  parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last,
  output logic             valid,
  output logic [IDX_W-1:0] index
);

  // Requesters above `last` beat the wrapped ones; lowest index wins inside
  // each region, so both loops scan downward and the later loop overrides.
  always_comb begin
    valid = 1'b0;
    index = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[i] && (IDX_W'(i) <= last)) begin
        valid = 1'b1;
        index = IDX_W'(i);
      end
    end
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[i] && (IDX_W'(i) > last)) begin
        valid = 1'b1;
        index = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/iic_arbiter.sv
// Round-robin arbiter sharing one IIC_module command port among N_REQ
// requesters using the hold-until-done handshake, with a watchdog.
module iic_arbiter
  import iic_pkg::*;
#(
  parameter int N_REQ       = 3,
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = 65536,
  parameter int IDX_W       = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [2*N_REQ-1:0]       req_call,
  input  logic [ADDR_W*N_REQ-1:0]  req_addr,
  input  logic [DATA_W*N_REQ-1:0]  req_wdata,
  output logic [N_REQ-1:0]         req_done,
  output logic                     req_err,
  output logic [DATA_W-1:0]        rdata,
  output logic [1:0]               iic_call,
  output logic [ADDR_W-1:0]        iic_addr,
  output logic [DATA_W-1:0]        iic_wdata,
  input  logic [DATA_W-1:0]        iic_rdata,
  input  logic                     iic_done,
  output logic                     busy,
  output logic [IDX_W-1:0]         grant_id
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  state_t             state;
  logic [IDX_W-1:0]   last;
  logic [CNT_W-1:0]   cnt;

  logic [N_REQ-1:0]   pending;
  logic [1:0]         call_a  [N_REQ];
  logic [ADDR_W-1:0]  addr_a  [N_REQ];
  logic [DATA_W-1:0]  wdata_a [N_REQ];

  logic               pick_valid;
  logic [IDX_W-1:0]   pick_idx;

  for (genvar k = 0; k < N_REQ; k++) begin : g_req
    assign call_a[k]  = req_call[2*k +: 2];
    assign addr_a[k]  = req_addr[ADDR_W*k +: ADDR_W];
    assign wdata_a[k] = req_wdata[DATA_W*k +: DATA_W];
    assign pending[k] = |req_call[2*k +: 2];
  end

  iic_rr_pick #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_pick (
    .req   (pending),
    .last  (last),
    .valid (pick_valid),
    .index (pick_idx)
  );

  // Arbiter FSM: latch a request, drive IIC_module, report completion.
  // iic_call/iic_addr/iic_wdata double as the latched request during ISSUE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      last      <= IDX_W'(N_REQ - 1);
      cnt       <= '0;
      req_done  <= '0;
      req_err   <= 1'b0;
      rdata     <= '0;
      iic_call  <= CALL_NONE;
      iic_addr  <= '0;
      iic_wdata <= '0;
      busy      <= 1'b0;
      grant_id  <= '0;
    end else begin
      req_done <= '0;
      req_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            grant_id <= pick_idx;
            last     <= pick_idx;
            busy     <= 1'b1;
            if (call_a[pick_idx] == CALL_BAD) begin
              state    <= DONE;
              req_done <= N_REQ'(1) << pick_idx;
              req_err  <= 1'b1;
            end else begin
              state     <= ISSUE;
              iic_call  <= call_a[pick_idx];
              iic_addr  <= addr_a[pick_idx];
              iic_wdata <= wdata_a[pick_idx];
              cnt       <= '0;
            end
          end
        end
        ISSUE: begin
          cnt <= cnt + CNT_W'(1);
          if (iic_done) begin
            if (iic_call == CALL_READ) rdata <= iic_rdata;
            iic_call <= CALL_NONE;
            state    <= DONE;
            req_done <= N_REQ'(1) << grant_id;
          end else if (cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
            iic_call <= CALL_NONE;
            state    <= DONE;
            req_done <= N_REQ'(1) << grant_id;
            req_err  <= 1'b1;
          end
        end
        DONE: state <= HOLD;
        HOLD: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iic_arbiter.sv
// Self-checking bench for iic_arbiter: directed scenarios plus a randomized
// phase checked against a transaction-level model of the arbitration rules.
module tb_iic_arbiter;

  localparam int N  = 3;
  localparam int TO = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [1:0]      cl   [N];
  logic [7:0]      ad   [N];
  logic [7:0]      wd   [N];
  logic [2*N-1:0]  req_call;
  logic [8*N-1:0]  req_addr;
  logic [8*N-1:0]  req_wdata;
  logic [N-1:0]    req_done;
  logic            req_err;
  logic [7:0]      rdata;
  logic [1:0]      iic_call;
  logic [7:0]      iic_addr;
  logic [7:0]      iic_wdata;
  logic [7:0]      iic_rdata;
  logic            iic_done;
  logic            busy;
  logic [1:0]      grant_id;

  assign req_call  = {cl[2], cl[1], cl[0]};
  assign req_addr  = {ad[2], ad[1], ad[0]};
  assign req_wdata = {wd[2], wd[1], wd[0]};

  iic_arbiter #(.N_REQ(N), .ADDR_W(8), .DATA_W(8), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst),
    .req_call(req_call), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_done(req_done), .req_err(req_err), .rdata(rdata),
    .iic_call(iic_call), .iic_addr(iic_addr), .iic_wdata(iic_wdata),
    .iic_rdata(iic_rdata), .iic_done(iic_done),
    .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int low_run = 100;       // consecutive samples with iic_call idle
  int last = N - 1;        // model: last granted requester
  logic [7:0] exp_rdata = 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (iic_call == 2'b00) low_run++;
  endtask

  // Model: first requester after the last grant, wrapping, with a call.
  function automatic int model_pick();
    for (int o = 1; o <= N; o++) begin
      int c = (last + o) % N;
      if (cl[c] != 2'b00) return c;
    end
    return -1;
  endfunction

  // One full transaction from the IDLE scan to the next IDLE sample.
  // dly = cycles of iic_call before the IIC model answers (>= TO: never).
  task automatic txn(input int k, input int dly, input logic [7:0] rd, input bit drop);
    int n, hi;
    logic [1:0] call;
    call = cl[k];
    iic_rdata = rd;
    n = 0;
    do begin step(); n++; end while (!busy && n < 20);
    chk("busy_on_grant", busy, 1);
    chk("grant_id", grant_id, k);
    if (call == 2'b11) begin
      chk("bad_no_call", iic_call, 0);
      chk("bad_done", req_done, 1 << k);
      chk("bad_err", req_err, 1);
    end else begin
      chk("gap_ge3", low_run >= 3, 1);
      low_run = 0;
      chk("iic_call", iic_call, call);
      chk("iic_addr", iic_addr, ad[k]);
      chk("iic_wdata", iic_wdata, wd[k]);
      hi = 0; n = 0;
      while (req_done == 0 && n < TO + 8) begin
        if (iic_call != 2'b00) hi++;
        iic_done = (iic_call != 2'b00) && (hi == dly);
        step(); n++;
      end
      iic_done = 1'b0;
      chk("call_cycles", hi, (dly < TO) ? dly : TO);
      chk("done_onehot", req_done, 1 << k);
      chk("done_err", req_err, (dly >= TO) ? 1 : 0);
      chk("call_cleared", iic_call, 0);
      if (call == 2'b01 && dly < TO) exp_rdata = rd;
      chk("rdata", rdata, exp_rdata);
    end
    last = k;
    if (drop) cl[k] = 2'b00;
    step();
    chk("hold_no_done", req_done, 0);
    chk("hold_busy", busy, 1);
    chk("hold_call", iic_call, 0);
    step();
    chk("idle_busy", busy, 0);
    chk("idle_call", iic_call, 0);
  endtask

  initial begin
    int k, d;
    rst = 1'b1; iic_done = 1'b0; iic_rdata = 8'h00;
    for (int i = 0; i < N; i++) begin cl[i] = 2'b00; ad[i] = 8'h00; wd[i] = 8'h00; end
    step(); step();
    rst = 1'b0;
    chk("rst_call", iic_call, 0);
    chk("rst_addr", iic_addr, 0);
    chk("rst_wdata", iic_wdata, 0);
    chk("rst_done", req_done, 0);
    chk("rst_err", req_err, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant_id, 0);

    // Write from requester 0
    cl[0] = 2'b10; ad[0] = 8'h00; wd[0] = 8'hAB;
    txn(0, 12, 8'h55, 1'b1);

    // Read from requester 1
    cl[1] = 2'b01; ad[1] = 8'h02; wd[1] = 8'h00;
    txn(1, 5, 8'hEF, 1'b1);

    // Timeout: IIC model never answers
    cl[0] = 2'b10; ad[0] = 8'h10; wd[0] = 8'h3C;
    txn(0, 1000, 8'h00, 1'b1);

    // Illegal call
    cl[2] = 2'b11;
    txn(2, 1, 8'h00, 1'b1);

    // Fairness: everyone holds a write; expect 0,1,2,0
    for (int i = 0; i < N; i++) begin cl[i] = 2'b10; ad[i] = 8'(i + 4); wd[i] = 8'(i * 17); end
    for (int r = 0; r < 4; r++) begin
      k = model_pick();
      chk("fair_model", k, r % N);
      txn(k, 3 + r, 8'h00, 1'b0);
    end
    for (int i = 0; i < N; i++) cl[i] = 2'b00;

    // Randomized phase
    for (int it = 0; it < 24; it++) begin
      for (int i = 0; i < N; i++) begin
        if (cl[i] == 2'b00) begin
          d = $urandom_range(0, 7);
          cl[i] = (d < 3) ? 2'b00 : (d < 5) ? 2'b10 : (d < 7) ? 2'b01 : 2'b11;
          ad[i] = 8'($urandom);
          wd[i] = 8'($urandom);
        end
      end
      if (model_pick() < 0) cl[$urandom_range(0, N - 1)] = 2'b01;
      k = model_pick();
      d = $urandom_range(1, 18);
      txn(k, d, 8'($urandom), 1'b1);
    end
    for (int i = 0; i < N; i++) cl[i] = 2'b00;
    step();

    // Reset in the middle of ISSUE
    cl[0] = 2'b10; ad[0] = 8'h77; wd[0] = 8'h99;
    d = 0;
    do begin step(); d++; end while (!busy && d < 20);
    chk("pre_rst_call", iic_call, 2'b10);
    step(); step(); step();
    rst = 1'b1;
    step();
    chk("midrst_call", iic_call, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", req_done, 0);
    chk("midrst_grant", grant_id, 0);
    chk("midrst_rdata", rdata, 0);
    cl[0] = 2'b00;
    rst = 1'b0;
    last = N - 1; exp_rdata = 8'h00; low_run = 100;
    step();
    // Stray done while IDLE
    iic_done = 1'b1;
    step();
    iic_done = 1'b0;
    chk("stray_done", req_done, 0);
    chk("stray_busy", busy, 0);
    step();
    chk("stray_done2", req_done, 0);
    chk("stray_call", iic_call, 0);

    // Simultaneous 0/1 after reset: 0 first
    cl[0] = 2'b10; ad[0] = 8'h01; wd[0] = 8'h11;
    cl[1] = 2'b01; ad[1] = 8'h02; wd[1] = 8'h22;
    chk("post_rst_model", model_pick(), 0);
    txn(0, 4, 8'h00, 1'b1);
    txn(1, 6, 8'hC3, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
